// File: rtl/pc_fetch_stage.sv
// Fetch-stage controller: owns the PC, issues instruction-memory requests and
// loads the IF/ID register, with redirect, stall and a one-entry hold buffer.
module pc_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] PCAddResult,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   input  logic        Jump,
   input  logic [31:0] JumpTarget,
   input  logic        Stall,
   input  logic        IMemReady,
   input  logic [31:0] IMemData,
   output logic [31:0] PCResult,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   output logic [31:0] IFID_Instr,
   output logic [31:0] IFID_PCPlus4,
   output logic        IFID_Valid
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, w_pc_nxt;
   logic [31:0] r_instr, w_instr_nxt;
   logic [31:0] r_pc4, w_pc4_nxt;
   logic        r_valid, w_valid_nxt;
   logic [31:0] r_buf_instr, w_buf_instr_nxt;
   logic [31:0] r_buf_pc4, w_buf_pc4_nxt;
   logic        w_redirect;
   logic [31:0] w_target;

   assign w_redirect = BranchTaken | Jump;
   assign w_target   = BranchTaken ? {BranchTarget[31:2], 2'b00}
                                   : {JumpTarget[31:2], 2'b00};

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state     <= S_IDLE;
         r_pc        <= RESET_PC;
         r_instr     <= 32'h0;
         r_pc4       <= 32'h0;
         r_valid     <= 1'b0;
         r_buf_instr <= 32'h0;
         r_buf_pc4   <= 32'h0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_instr     <= w_instr_nxt;
         r_pc4       <= w_pc4_nxt;
         r_valid     <= w_valid_nxt;
         r_buf_instr <= w_buf_instr_nxt;
         r_buf_pc4   <= w_buf_pc4_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_instr_nxt     = r_instr;
      w_pc4_nxt       = r_pc4;
      // No delivery: a stall freezes IF/ID, otherwise decode sees a bubble.
      w_valid_nxt     = Stall ? r_valid : 1'b0;
      w_buf_instr_nxt = r_buf_instr;
      w_buf_pc4_nxt   = r_buf_pc4;
      if (w_redirect) begin
         w_pc_nxt    = w_target;
         w_valid_nxt = 1'b0;
         w_state_nxt = S_REQ;
      end else begin
         case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ: begin
               if (IMemReady && !Stall) begin
                  w_instr_nxt = IMemData;
                  w_pc4_nxt   = PCAddResult;
                  w_valid_nxt = 1'b1;
                  w_pc_nxt    = PCAddResult;
               end else if (IMemReady && Stall) begin
                  w_buf_instr_nxt = IMemData;
                  w_buf_pc4_nxt   = PCAddResult;
                  w_state_nxt     = S_HOLD;
               end
            end
            S_HOLD: begin
               if (!Stall) begin
                  w_instr_nxt = r_buf_instr;
                  w_pc4_nxt   = r_buf_pc4;
                  w_valid_nxt = 1'b1;
                  w_pc_nxt    = r_buf_pc4;
                  w_state_nxt = S_REQ;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   assign IMemReq      = (r_state == S_REQ);
   assign IMemAddr     = r_pc;
   assign PCResult     = r_pc;
   assign IFID_Instr   = r_instr;
   assign IFID_PCPlus4 = r_pc4;
   assign IFID_Valid   = r_valid;

endmodule
